// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a gate
// window of GATE clk_in cycles. A result is presented on count_out and
// overflow with a one-cycle valid strobe. Operation is single-shot (start)
// or back-to-back (continuous).
module freq_meter #(
   parameter int GATE = 100000000,
   parameter int CW   = 31
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          sig_in,
   input  logic          start,
   input  logic          continuous,
   output logic          busy,
   output logic [CW-1:0] count_out,
   output logic          valid,
   output logic          overflow
);

   localparam int GW = (GATE > 2) ? $clog2(GATE) : 1;
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;
   logic [GW-1:0] gate_q, gate_d;
   logic [CW-1:0] edge_q, edge_d;
   logic          sat_q, sat_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          rise;
   logic          sat_hit;
   logic [CW-1:0] edge_inc;
   logic          gate_end;

   // Input synchronizer and rise detector; edge counter saturates instead of wrapping
   always_comb begin
      sync1_d  = sig_in;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      rise     = sync2_q & ~prev_q;
      sat_hit  = rise && (edge_q == CNT_MAX);
      edge_inc = edge_q;
      if (rise && !sat_hit) begin
         edge_inc = edge_q + CW'(1);
      end
      gate_end = (gate_q == GATE_LAST);
   end

   // Next-state logic: IDLE -> COUNT (GATE cycles) -> DONE (one cycle)
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start || continuous) begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (gate_end) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = continuous ? S_COUNT : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Counter datapath; the result is latched on entry to DONE so that it is
   // already visible in the cycle valid is high, including a rise in the last
   // COUNT cycle. A rise during DONE falls into the dead time and is dropped.
   always_comb begin
      gate_d  = gate_q;
      edge_d  = edge_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start || continuous) begin
               gate_d = '0;
               edge_d = '0;
               sat_d  = 1'b0;
            end
         end
         S_COUNT: begin
            gate_d = gate_q + GW'(1);
            edge_d = edge_inc;
            sat_d  = sat_q | sat_hit;
            if (gate_end) begin
               count_d = edge_inc;
               ovf_d   = sat_q | sat_hit;
               sat_d   = 1'b0;
            end
         end
         S_DONE: begin
            if (continuous) begin
               gate_d = '0;
               edge_d = '0;
               sat_d  = 1'b0;
            end
         end
         default: begin
            gate_d = '0;
            edge_d = '0;
            sat_d  = 1'b0;
         end
      endcase
   end

   // All state, including the synchronizer, clears on asynchronous reset
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         gate_q  <= '0;
         edge_q  <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         gate_q  <= gate_d;
         edge_q  <= edge_d;
         sat_q   <= sat_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Outputs decoded straight from flops
   always_comb begin
      busy      = (state_q == S_COUNT) || (state_q == S_DONE);
      valid     = (state_q == S_DONE);
      count_out = count_q;
      overflow  = ovf_q;
   end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with GATE=100: a CW=31 and a CW=4 instance
// share all inputs; table-driven single-shot runs plus hand-written
// sequences for continuous mode, ignored start and mid-window reset.
module tb_freq_meter;
   localparam int GATE = 100;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        sig_in;
   logic        start;
   logic        continuous;
   logic        busy, valid, overflow;
   logic [30:0] count_out;
   logic        busy4, valid4, overflow4;
   logic [3:0]  count4;

   int checks = 0;
   int errors = 0;

   // signal generator state: mode 0 = low, 1 = high, 2 = square wave
   int gen_mode = 0;
   int hi_len   = 1;
   int lo_len   = 1;
   int ph       = 0;

   typedef struct {
      int    mode;
      int    hi;
      int    lo;
      int    phase;
      bit    use4;
      int    exp_lo;
      int    exp_hi;
      int    exp_ovf;
      string name;
   } vec_t;

   vec_t vecs [8];

   freq_meter #(.GATE(GATE), .CW(31)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .sig_in     (sig_in),
      .start      (start),
      .continuous (continuous),
      .busy       (busy),
      .count_out  (count_out),
      .valid      (valid),
      .overflow   (overflow)
   );

   freq_meter #(.GATE(GATE), .CW(4)) dut4 (
      .clk_in     (clk_in),
      .reset      (reset),
      .sig_in     (sig_in),
      .start      (start),
      .continuous (continuous),
      .busy       (busy4),
      .count_out  (count4),
      .valid      (valid4),
      .overflow   (overflow4)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clk_in);
         if (gen_mode == 0) begin
            sig_in = 1'b0;
         end else if (gen_mode == 1) begin
            sig_in = 1'b1;
         end else begin
            sig_in = (ph < hi_len);
            ph = ph + 1;
            if (ph >= hi_len + lo_len) ph = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input logic [31:0] act,
                              input int lo, input int hi);
      checks++;
      if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic set_pat(input int mode, input int hi, input int lo, input int phase);
      gen_mode = mode;
      hi_len   = hi;
      lo_len   = lo;
      ph       = phase;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
   endtask

   // counts valid strobes of the main instance over n cycles
   task automatic count_valids(input int n, output int nv);
      nv = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         if (valid) nv++;
      end
   endtask

   task automatic run_single(input vec_t v);
      int lat;
      bit got;
      logic [31:0] cnt;
      logic        ovf;
      set_pat(v.mode, v.hi, v.lo, v.phase);
      repeat (20) @(negedge clk_in);
      pulse_start();
      check({v.name, "_busy_start"}, 32'(busy), 32'd1);
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk_in);
         lat++;
         if (v.use4 ? valid4 : valid) got = 1'b1;
      end
      cnt = v.use4 ? 32'(count4) : 32'(count_out);
      ovf = v.use4 ? overflow4 : overflow;
      check({v.name, "_latency"}, 32'(lat), 32'(GATE + 1));
      check_range({v.name, "_count"}, cnt, v.exp_lo, v.exp_hi);
      check({v.name, "_overflow"}, 32'(ovf), 32'(v.exp_ovf));
      @(negedge clk_in);
      check({v.name, "_valid_drop"}, 32'(v.use4 ? valid4 : valid), 32'd0);
      check({v.name, "_busy_drop"}, 32'(v.use4 ? busy4 : busy), 32'd0);
   endtask

   initial begin : main
      int nv, gap, lat;
      bit got;

      vecs[0] = '{2, 5, 5, 0, 1'b0, 10, 10, 0, "sq_p10"};
      vecs[1] = '{0, 1, 1, 0, 1'b0, 0, 0, 0, "held_low"};
      vecs[2] = '{1, 1, 1, 0, 1'b0, 0, 0, 0, "held_high"};
      vecs[3] = '{2, 2, 2, 0, 1'b1, 15, 15, 1, "cw4_p4_sat"};
      vecs[4] = '{2, 10, 10, 3, 1'b1, 5, 5, 0, "cw4_p20"};
      vecs[5] = '{2, 1, 1, 1, 1'b0, 49, 51, 0, "sq_p2"};
      vecs[6] = '{2, 2, 2, 1, 1'b0, 25, 25, 0, "sq_p4"};
      vecs[7] = '{2, 13, 12, 7, 1'b0, 4, 4, 0, "sq_p25"};

      reset      = 1'b1;
      start      = 1'b0;
      continuous = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_count", 32'(count_out), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_count4", 32'(count4), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk_in);
      check("idle_busy", 32'(busy), 32'd0);

      for (int k = 0; k < 8; k++) begin
         run_single(vecs[k]);
      end

      // continuous mode, period 25
      set_pat(2, 13, 12, 0);
      repeat (20) @(negedge clk_in);
      continuous = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk_in);
         if (valid) got = 1'b1;
      end
      check("cont_first_valid", 32'(got), 32'd1);
      check("cont_count_0", 32'(count_out), 32'd4);
      for (int k = 1; k <= 3; k++) begin
         gap = 0;
         got = 1'b0;
         for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_in);
            gap++;
            if (valid) got = 1'b1;
         end
         check($sformatf("cont_period_%0d", k), 32'(gap), 32'(GATE + 1));
         check($sformatf("cont_count_%0d", k), 32'(count_out), 32'd4);
      end
      repeat (50) @(negedge clk_in);
      continuous = 1'b0;
      count_valids(250, nv);
      check("cont_tail_valids", 32'(nv), 32'd1);
      check("cont_tail_busy", 32'(busy), 32'd0);

      // start during COUNT is ignored
      set_pat(2, 2, 2, 0);
      repeat (20) @(negedge clk_in);
      pulse_start();
      lat = 1;
      repeat (49) begin
         @(negedge clk_in);
         lat++;
      end
      pulse_start();
      lat++;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk_in);
         lat++;
         if (valid) got = 1'b1;
      end
      check("ign_latency", 32'(lat), 32'(GATE + 1));
      check("ign_count", 32'(count_out), 32'd25);
      check("ign_count4", 32'(count4), 32'd15);
      check("ign_overflow4", 32'(overflow4), 32'd1);
      count_valids(200, nv);
      check("ign_no_extra_valid", 32'(nv), 32'd0);
      check("ign_busy", 32'(busy), 32'd0);

      // reset in the middle of a window
      pulse_start();
      repeat (59) @(negedge clk_in);
      check("mid_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_count", 32'(count_out), 32'd0);
      check("mid_rst_count4", 32'(count4), 32'd0);
      check("mid_rst_overflow4", 32'(overflow4), 32'd0);
      @(negedge clk_in);
      @(negedge clk_in);
      reset = 1'b0;
      count_valids(250, nv);
      check("mid_rst_no_valid", 32'(nv), 32'd0);
      check("mid_rst_busy_after", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
